// File: rtl/bcd_rate_counter.sv
// bcd_rate_counter: multi-digit BCD up/down counter stepping at one of four
// divided rates of CLOCK_50, with pause, synchronous clear, saturating
// parallel load, rollover pulse and per-digit active-low 7-segment decode.
//
// Ports:
//   CLOCK_50   in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   speed_sel  in   [1:0] selects terminal count DIV0..DIV3
//   run        in   1 = divider and counter advance, 0 = hold
//   up         in   1 = count up, 0 = count down (sampled on step edges)
//   clear      in   synchronous clear of divider and digits (highest priority)
//   load       in   synchronous parallel load of load_val (digits >9 load as 9)
//   load_val   in   [4*DIGITS-1:0] BCD load value, digit 0 in [3:0]
//   digits_o   out  [4*DIGITS-1:0] current BCD value, registered
//   hex_o      out  [7*DIGITS-1:0] active-low {g,f,e,d,c,b,a}, digit 0 in [6:0]
//   tick_o     out  one-cycle pulse on each step edge, registered
//   wrap_o     out  one-cycle pulse on rollover, registered
module bcd_rate_counter #(
   parameter int DIGITS = 2,
   parameter int DIV_W  = 28,
   parameter int DIV0   = 0,
   parameter int DIV1   = 24999999,
   parameter int DIV2   = 49999999,
   parameter int DIV3   = 99999999
) (
   input  logic                  CLOCK_50,
   input  logic                  resetn,
   input  logic [1:0]            speed_sel,
   input  logic                  run,
   input  logic                  up,
   input  logic                  clear,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   output logic [4*DIGITS-1:0]   digits_o,
   output logic [7*DIGITS-1:0]   hex_o,
   output logic                  tick_o,
   output logic                  wrap_o
);

   localparam int BW = 4 * DIGITS;

   logic [DIV_W-1:0] r_cnt;
   logic [BW-1:0]    r_digits;
   logic             r_tick;
   logic             r_wrap;

   logic [DIV_W-1:0] w_div_sel;
   logic [BW-1:0]    w_inc;
   logic [BW-1:0]    w_dec;
   logic [BW-1:0]    w_sat;
   logic             w_all9;
   logic             w_all0;

   // Terminal count follows speed_sel combinationally; a lowered rate is
   // caught by the cnt > div_sel branch below.
   always_comb begin
      w_div_sel = DIV_W'(DIV0);
      case (speed_sel)
         2'd0: w_div_sel = DIV_W'(DIV0);
         2'd1: w_div_sel = DIV_W'(DIV1);
         2'd2: w_div_sel = DIV_W'(DIV2);
         2'd3: w_div_sel = DIV_W'(DIV3);
         default: w_div_sel = DIV_W'(DIV0);
      endcase
   end

   // Ripple-carry increment / ripple-borrow decrement across the BCD digits.
   // When every digit carries (all 9) or borrows (all 0) the result wraps.
   always_comb begin
      logic carry;
      logic borrow;
      w_inc  = r_digits;
      w_dec  = r_digits;
      w_all9 = 1'b1;
      w_all0 = 1'b1;
      carry  = 1'b1;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_digits[4*i +: 4] != 4'd9) w_all9 = 1'b0;
         if (r_digits[4*i +: 4] != 4'd0) w_all0 = 1'b0;
         if (carry) begin
            if (r_digits[4*i +: 4] == 4'd9) begin
               w_inc[4*i +: 4] = 4'd0;
            end else begin
               w_inc[4*i +: 4] = r_digits[4*i +: 4] + 4'd1;
               carry = 1'b0;
            end
         end
         if (borrow) begin
            if (r_digits[4*i +: 4] == 4'd0) begin
               w_dec[4*i +: 4] = 4'd9;
            end else begin
               w_dec[4*i +: 4] = r_digits[4*i +: 4] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   end

   // Load value with each non-BCD nibble clamped to 9.
   always_comb begin
      w_sat = load_val;
      for (int i = 0; i < DIGITS; i++) begin
         if (load_val[4*i +: 4] > 4'd9) w_sat[4*i +: 4] = 4'd9;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_cnt    <= '0;
         r_digits <= '0;
         r_tick   <= 1'b0;
         r_wrap   <= 1'b0;
      end else if (clear) begin
         r_cnt    <= '0;
         r_digits <= '0;
         r_tick   <= 1'b0;
         r_wrap   <= 1'b0;
      end else if (load) begin
         r_cnt    <= '0;
         r_digits <= w_sat;
         r_tick   <= 1'b0;
         r_wrap   <= 1'b0;
      end else if (!run) begin
         r_tick   <= 1'b0;
         r_wrap   <= 1'b0;
      end else if (r_cnt > w_div_sel) begin
         r_cnt    <= '0;
         r_tick   <= 1'b0;
         r_wrap   <= 1'b0;
      end else if (r_cnt == w_div_sel) begin
         r_cnt    <= '0;
         r_tick   <= 1'b1;
         if (up) begin
            r_digits <= w_inc;
            r_wrap   <= w_all9;
         end else begin
            r_digits <= w_dec;
            r_wrap   <= w_all0;
         end
      end else begin
         r_cnt    <= r_cnt + 1'b1;
         r_tick   <= 1'b0;
         r_wrap   <= 1'b0;
      end
   end

   function automatic logic [6:0] f_seg(input logic [3:0] d);
      case (d)
         4'd0:    f_seg = 7'b1000000;
         4'd1:    f_seg = 7'b1111001;
         4'd2:    f_seg = 7'b0100100;
         4'd3:    f_seg = 7'b0110000;
         4'd4:    f_seg = 7'b0011001;
         4'd5:    f_seg = 7'b0010010;
         4'd6:    f_seg = 7'b0000010;
         4'd7:    f_seg = 7'b1111000;
         4'd8:    f_seg = 7'b0000000;
         4'd9:    f_seg = 7'b0010000;
         default: f_seg = 7'b1111111;
      endcase
   endfunction

   always_comb begin
      hex_o = '1;
      for (int i = 0; i < DIGITS; i++) begin
         hex_o[7*i +: 7] = f_seg(r_digits[4*i +: 4]);
      end
   end

   assign digits_o = r_digits;
   assign tick_o   = r_tick;
   assign wrap_o   = r_wrap;

endmodule

// File: tb/tb_bcd_rate_counter.sv
// tb_bcd_rate_counter: randomized and directed stimulus for bcd_rate_counter
// (DIGITS=2, DIV=0/3/4/9), checked every cycle against an integer-valued
// reference model of the counter.
module tb_bcd_rate_counter;

   logic        CLOCK_50;
   logic        resetn;
   logic [1:0]  speed_sel;
   logic        run;
   logic        up;
   logic        clear;
   logic        load;
   logic [7:0]  load_val;
   logic [7:0]  digits_o;
   logic [13:0] hex_o;
   logic        tick_o;
   logic        wrap_o;

   bcd_rate_counter #(
      .DIGITS(2), .DIV_W(28), .DIV0(0), .DIV1(3), .DIV2(4), .DIV3(9)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .resetn   (resetn),
      .speed_sel(speed_sel),
      .run      (run),
      .up       (up),
      .clear    (clear),
      .load     (load),
      .load_val (load_val),
      .digits_o (digits_o),
      .hex_o    (hex_o),
      .tick_o   (tick_o),
      .wrap_o   (wrap_o)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: counter value as a plain integer 0..99.
   int m_val;
   int m_cnt;
   int m_tick;
   int m_wrap;
   int div_tab [4] = '{0, 3, 4, 9};
   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
                                7'b0110000, 7'b0011001, 7'b0010010,
                                7'b0000010, 7'b1111000, 7'b0000000,
                                7'b0010000};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_val = 0; m_cnt = 0; m_tick = 0; m_wrap = 0;
   endtask

   task automatic model_edge();
      int d;
      int hi;
      int lo;
      if (!resetn) begin
         model_reset();
         return;
      end
      d = div_tab[speed_sel];
      m_tick = 0;
      m_wrap = 0;
      if (clear) begin
         m_cnt = 0; m_val = 0;
      end else if (load) begin
         hi = int'(load_val[7:4]); lo = int'(load_val[3:0]);
         if (hi > 9) hi = 9;
         if (lo > 9) lo = 9;
         m_cnt = 0; m_val = hi * 10 + lo;
      end else if (!run) begin
         // hold
      end else if (m_cnt > d) begin
         m_cnt = 0;
      end else if (m_cnt == d) begin
         m_cnt  = 0;
         m_tick = 1;
         if (up) begin
            m_wrap = (m_val == 99) ? 1 : 0;
            m_val  = (m_val + 1) % 100;
         end else begin
            m_wrap = (m_val == 0) ? 1 : 0;
            m_val  = (m_val + 99) % 100;
         end
      end else begin
         m_cnt++;
      end
   endtask

   task automatic check_all(input string tag);
      logic [7:0]  e_dig;
      logic [13:0] e_hex;
      e_dig = {4'(m_val / 10), 4'(m_val % 10)};
      e_hex = {seg_tab[m_val / 10], seg_tab[m_val % 10]};
      chk({tag, ".digits"}, 32'(digits_o), 32'(e_dig));
      chk({tag, ".hex"},    32'(hex_o),    32'(e_hex));
      chk({tag, ".tick"},   32'(tick_o),   32'(m_tick));
      chk({tag, ".wrap"},   32'(wrap_o),   32'(m_wrap));
   endtask

   // One clock edge: model follows the edge, outputs sampled 1 ns later.
   task automatic cyc(input string tag);
      @(posedge CLOCK_50);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic cycles(input string tag, input int n);
      for (int i = 0; i < n; i++) cyc(tag);
   endtask

   task automatic set_in(input logic [1:0] s, input logic r, input logic u,
                         input logic c, input logic l, input logic [7:0] lv);
      speed_sel = s; run = r; up = u; clear = c; load = l; load_val = lv;
   endtask

   initial begin
      resetn = 1'b0;
      set_in(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      model_reset();
      #3;
      check_all("reset");
      cycles("reset_hold", 2);
      resetn = 1'b1;

      // Up count at 4-cycle spacing: 00 -> 01 -> 02 -> 03.
      set_in(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      cycles("up_s1", 14);

      // Up wrap 98 -> 99 -> 00 at one step per cycle.
      set_in(2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h98);
      cyc("load98");
      load = 1'b0; run = 1'b1;
      cycles("up_wrap", 4);

      // Down borrow 10 -> 09 ... -> 00 -> 99.
      set_in(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
      cyc("load10");
      load = 1'b0; run = 1'b1;
      cycles("down_wrap", 13);

      // Rate lowered mid-count: reach cnt=7 at speed 3, then drop to speed 1.
      set_in(2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 8'h42);
      cyc("load42");
      load = 1'b0; run = 1'b1;
      cycles("s3_to7", 7);
      speed_sel = 2'd1;
      cycles("rate_drop", 10);

      // Pause for 20 cycles, then resume.
      run = 1'b0;
      cycles("pause", 20);
      run = 1'b1;
      cycles("resume", 6);

      // Clear during run, and clear beating a simultaneous load.
      clear = 1'b1;
      cyc("clear");
      load = 1'b1; load_val = 8'h55;
      cyc("clear_over_load");
      clear = 1'b0; load = 1'b0;
      cycles("post_clear", 5);

      // Saturating load of non-BCD nibbles.
      set_in(2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFA);
      cyc("load_sat");
      load = 1'b0; run = 1'b1;
      cycles("after_sat", 7);

      // Asynchronous reset between edges.
      #2;
      resetn = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      chk("async_rst.hex_literal", 32'(hex_o), 32'(14'b1000000_1000000));
      cycles("rst_low", 2);
      resetn = 1'b1;
      cycles("rst_release", 8);

      // Randomized phase.
      for (int i = 0; i < 3000; i++) begin
         speed_sel = 2'($urandom_range(0, 3));
         run       = ($urandom_range(0, 7) != 0);
         up        = 1'($urandom);
         clear     = ($urandom_range(0, 63) == 0);
         load      = ($urandom_range(0, 31) == 0);
         load_val  = 8'($urandom);
         if ($urandom_range(0, 399) == 0) begin
            #2;
            resetn = 1'b0;
            model_reset();
            #1;
            check_all("rand_async_rst");
            cyc("rand_rst_low");
            resetn = 1'b1;
         end else begin
            cyc("rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
